// File: rtl/seven_seg_scan_capture.sv
// Passive sniffer for a multiplexed active-low 7-segment bus; rebuilds the shown hex word.
// Optional blank detection: define SEVEN_SEG_BLANK_DETECT_EN to accept all-off as a legal blank.
module seven_seg_scan_capture #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_SAMPLES = 3,
    parameter int SAMPLE_DELAY   = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [6:0]              segs,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    valid,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic [NUM_DIGITS-1:0]   blank
);

    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(SAMPLE_DELAY + 1);
    localparam int MW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [NUM_DIGITS-1:0] ONE  = NUM_DIGITS'(1);
    localparam logic [MW-1:0]         MMAX = MW'(STABLE_SAMPLES);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, WAIT} state_t;

    state_t                state, state_nx;
    logic [6:0]            segs_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [NUM_DIGITS-1:0] low;
    logic                  sel_ok;
    logic [SW-1:0]         sel, sel_q;
    logic [CW-1:0]         cnt;
    logic                  load, inc, take;
    logic [6:0]            pat;
    logic                  hex_ok, blank_ok;
    logic [3:0]            hex_val;
    logic [NUM_DIGITS-1:0] visited, vis_nx;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            segs_q <= 7'h7F;
            an_q   <= '1;
        end else begin
            segs_q <= segs;
            an_q   <= an;
        end
    end

    // Exactly one low anode is a legal select.
    assign low    = ~an_q;
    assign sel_ok = (low != '0) && ((low & (low - ONE)) == '0);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (low[i]) sel = SW'(i);
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (sel_ok) state_nx = SETTLE;
            SETTLE: begin
                if (!sel_ok)                          state_nx = IDLE;
                else if (sel != sel_q)                state_nx = SETTLE;
                else if (cnt == CW'(SAMPLE_DELAY-1))  state_nx = SAMPLE;
            end
            SAMPLE: state_nx = WAIT;
            WAIT: begin
                if (!sel_ok)           state_nx = IDLE;
                else if (sel != sel_q) state_nx = SETTLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        load = 1'b0;
        inc  = 1'b0;
        take = 1'b0;
        unique case (state)
            IDLE:   load = sel_ok;
            SETTLE: begin
                load = sel_ok && (sel != sel_q);
                inc  = sel_ok && (sel == sel_q);
            end
            SAMPLE: take = 1'b1;
            WAIT:   load = sel_ok && (sel != sel_q);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sel_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            sel_q <= sel;
            cnt   <= '0;
        end else if (inc) begin
            cnt   <= cnt + CW'(1);
        end
    end

    assign pat = ~segs_q;

    always_comb begin
        hex_ok  = 1'b1;
        hex_val = 4'h0;
        case (pat)
            7'h3F: hex_val = 4'h0;
            7'h06: hex_val = 4'h1;
            7'h5B: hex_val = 4'h2;
            7'h4F: hex_val = 4'h3;
            7'h66: hex_val = 4'h4;
            7'h6D: hex_val = 4'h5;
            7'h7D: hex_val = 4'h6;
            7'h07: hex_val = 4'h7;
            7'h7F: hex_val = 4'h8;
            7'h6F: hex_val = 4'h9;
            7'h77: hex_val = 4'hA;
            7'h7C: hex_val = 4'hB;
            7'h58: hex_val = 4'hC;
            7'h5E: hex_val = 4'hD;
            7'h79: hex_val = 4'hE;
            7'h71: hex_val = 4'hF;
            default: hex_ok = 1'b0;
        endcase
    end

`ifdef SEVEN_SEG_BLANK_DETECT_EN
    assign blank_ok = (pat == 7'h00);
`else
    assign blank_ok = 1'b0;
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pos
        logic [3:0]    shadow, dig;
        logic [MW-1:0] match, m_nx;
        logic          err, blk;
        logic          hit;

        assign hit = take && (sel_q == SW'(g));

        always_comb begin
            if (hex_val == shadow)
                m_nx = (match == MMAX) ? MMAX : match + MW'(1);
            else
                m_nx = MW'(1);
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                shadow <= '0;
                dig    <= '0;
                match  <= '0;
                err    <= 1'b0;
                blk    <= 1'b0;
            end else if (hit) begin
                if (hex_ok) begin
                    shadow <= hex_val;
                    match  <= m_nx;
                    err    <= 1'b0;
                    blk    <= 1'b0;
                    if (m_nx == MMAX) dig <= hex_val;
                end else if (blank_ok) begin
                    blk   <= 1'b1;
                    err   <= 1'b0;
                    match <= '0;
                end else begin
                    err   <= 1'b1;
                    match <= '0;
                end
            end
        end

        assign digits[4*g +: 4] = dig;
        assign digit_err[g]     = err;
        assign blank[g]         = blk;
    end

    assign vis_nx = visited | (ONE << sel_q);

    // Frame strobe fires the cycle after the sample that fills the mask.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            visited <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (take) begin
                if (vis_nx == '1) begin
                    visited <= '0;
                    valid   <= 1'b1;
                end else begin
                    visited <= vis_nx;
                end
            end
        end
    end

endmodule
